instr_packer: RTL and testbench
===============================

Name: instr_packer

Overview:
- Inverse of the core's immediate generator. Takes decoded instruction fields plus a 32-bit immediate and packs them into a 32-bit RV32I instruction word.
- Immediate bit-scrambling per format (I/S/B/U/J, shift-I), with range checks.
- Results are buffered in a 2-entry FIFO and tagged with a sequential instruction-memory word address.
- Used by the testbench program loader and the boot-time instruction writer to fill instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, address tagged on first packed word after reset/flush.
- ADDR_STEP, 4, address increment per accepted request.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of FIFO; address reloads BASE_ADDR
- in_valid  input  1  request valid
- in_ready  output  1  packer can accept a request
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal
- in_opcode  input  7  opcode
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type, and shift-I upper bits)
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_imm  input  32  byte-offset/value immediate, two's complement
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_instr  output  32  packed instruction
- out_addr  output  32  address tag of head
- out_err  output  1  head had illegal format or out-of-range immediate
- err_count  output  8  saturating count of errored requests

Behaviour:
- Reset (clk edge with reset=1):
  - FIFO emptied; out_valid=0, out_instr=0, out_addr=0, out_err=0.
  - err_count=0; address counter=BASE_ADDR; in_ready=1 on the following cycle.
- Accept: in_valid&in_ready at edge N. Entry pushed; out_valid=1 after edge N (latency 1). Address counter += ADDR_STEP, wrapping mod 2^32.
- Pop: out_valid&out_ready at edge pops head. Order strictly FIFO.
- in_ready = !full. No same-cycle pass-through when full, even if out_ready=1. Push and pop in one cycle when 1 entry is held: count unchanged.
- FIFO: 2 entries, 2-bit count, 1-bit read/write pointers wrap 1->0. Head is shown on out_* combinationally from storage.
- Packing, always rd->[11:7], rs1->[19:15], rs2->[24:20], funct3->[14:12], opcode->[6:0], with these format-specific fields:
  - R: funct7->[31:25].
  - I: imm[11:0]->[31:20]. For opcode 0010011 with funct3 001/101 (shift), [31:25]=funct7 and [24:20]=imm[4:0].
  - S: imm[11:5]->[31:25], imm[4:0]->[11:7].
  - B: imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7].
  - U: imm[31:12]->[31:12].
  - J: imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12].
  - Fields unused by a format are zero; the rd/rs1/rs2/funct3 placements above are overridden where a format puts immediate bits in those positions.
- Range rules, error when violated:
  - I, S: -2048..2047.
  - Shift-I: 0..31.
  - B: -4096..4094, bit0=0.
  - J: -1048576..1048574, bit0=0.
  - U: imm[11:0]=0.
  - Illegal fmt is always an error.
- Errored request: still accepted, still consumes an address. Stored out_instr=32'h0000_0013 (NOP), out_err=1. err_count increments, saturating at 255.
- flush at edge: FIFO emptied, address=BASE_ADDR, err_count retained. A request presented on the same edge is dropped and does not consume an address.
- reset overrides flush. Reset mid-stream discards all buffered entries.

Optional Feature:
- Macro INSTR_PACKER_CHECK_EN.
- Defined: range checks and NOP substitution as above.
- Undefined:
  - No range checks; immediates are silently truncated to the format's bits.
  - out_err=1 only for illegal fmt (NOP emitted).
  - err_count counts only illegal-fmt requests.

Test Plan:
- Reset, then ADDI: fmt=1, op=0x13, f3=0, rd=1, rs1=0, imm=-1 -> out_instr=0xFFF00093, out_addr=BASE_ADDR, out_err=0, out_valid one cycle after accept.
- SW: fmt=2, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423. Next BEQ: fmt=3, op=0x63, f3=0, rs1=0, rs2=0, imm=-4 -> 0xFE000EE3 at BASE_ADDR+4.
- JAL: fmt=5, op=0x6F, rd=1, imm=2048 -> 0x001000EF. SRAI: fmt=1, op=0x13, f3=5, f7=0x20, rd=5, rs1=5, imm=3 -> 0x4032D293.
- With CHECK_EN, ADDI imm=2048 -> out_instr=0x00000013, out_err=1, err_count=1. BEQ imm=3 -> error, err_count=2. Without CHECK_EN, the same ADDI -> 0x80000013, err=0.
- Backpressure: out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts, third held. Release -> order preserved, addresses BASE, +4, +8.
- flush with 1 entry held and in_valid=1 -> out_valid=0 next cycle. Next accepted request tagged BASE_ADDR. err_count unchanged.

Source files
------------

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - packs decoded RV32I fields and an immediate into an instruction word, 2-entry output FIFO
// Define INSTR_PACKER_CHECK_EN to enable immediate range checks with NOP substitution.
module instr_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0] instr_q [2];
  logic [31:0] addr_q  [2];
  logic [1:0]  err_q;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  logic [31:0] addr_cnt_q, addr_cnt_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        is_shift;
  logic        fmt_bad;
  logic        range_bad;
  logic        req_err;
  logic [31:0] packed_w;
  logic        push, pop;

  assign is_shift = (in_fmt == FMT_I) && (in_opcode == 7'h13) &&
                    ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

  always_comb begin
    packed_w = '0;
    fmt_bad  = 1'b0;
    case (in_fmt)
      FMT_R: packed_w = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        if (is_shift)
          packed_w = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
        else
          packed_w = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_S: packed_w = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: packed_w = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: packed_w = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: packed_w = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef INSTR_PACKER_CHECK_EN
  // Signed ranges are checked by requiring the bits above the field to be pure sign extension.
  logic fits_12, fits_13, fits_21;
  assign fits_12 = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits_13 = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign fits_21 = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

  always_comb begin
    range_bad = 1'b0;
    case (in_fmt)
      FMT_I:   range_bad = is_shift ? (in_imm[31:5] != '0) : !fits_12;
      FMT_S:   range_bad = !fits_12;
      FMT_B:   range_bad = !fits_13 || in_imm[0];
      FMT_U:   range_bad = (in_imm[11:0] != '0);
      FMT_J:   range_bad = !fits_21 || in_imm[0];
      default: range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign req_err = fmt_bad || range_bad;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? addr_q[rd_ptr_q]  : '0;
  assign out_err   = out_valid && err_q[rd_ptr_q];
  assign err_count = err_count_q;

  always_comb begin
    count_d     = count_q + {1'b0, push} - {1'b0, pop};
    addr_cnt_d  = push ? (addr_cnt_q + ADDR_STEP) : addr_cnt_q;
    err_count_d = err_count_q;
    if (push && req_err && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      addr_cnt_q  <= BASE_ADDR;
      err_count_q <= 8'd0;
    end else if (flush) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      addr_cnt_q <= BASE_ADDR;
    end else begin
      if (push) begin
        instr_q[wr_ptr_q] <= req_err ? NOP : packed_w;
        addr_q[wr_ptr_q]  <= addr_cnt_q;
        err_q[wr_ptr_q]   <= req_err;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      count_q     <= count_d;
      addr_cnt_q  <= addr_cnt_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// tb/tb_instr_packer.sv - directed and randomized checks of instr_packer against an arithmetic reference model
module tb_instr_packer;

  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef INSTR_PACKER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_err;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr, out_addr;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instr_packer #(.BASE_ADDR(BASE), .ADDR_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  int          tests = 0;
  int          fails = 0;
  ent_t        q[$];
  logic [31:0] m_addr;
  int          m_errs;
  logic [31:0] pend_instr;
  logic        pend_err;

  // Reference: places each immediate slice with division/modulo and range-tests the signed value.
  function automatic void model_pack(input int unsigned fmt, op, f3, f7, rd, rs1, rs2,
                                     input logic [31:0] imm,
                                     output logic [31:0] w, output logic e);
    int unsigned u;
    longint      s;
    bit          shift;
    u = imm;
    s = longint'($signed(imm));
    shift = (fmt == 1) && (op == 'h13) && (f3 == 1 || f3 == 5);
    e = 1'b0;
    w = '0;
    case (fmt)
      0: w = op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
      1: begin
        if (shift) begin
          w = op | rd << 7 | f3 << 12 | rs1 << 15 | (u % 32) << 20 | f7 << 25;
          e = CHK && (s < 0 || s > 31);
        end else begin
          w = op | rd << 7 | f3 << 12 | rs1 << 15 | (u % 4096) << 20;
          e = CHK && (s < -2048 || s > 2047);
        end
      end
      2: begin
        w = op | (u % 32) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((u / 32) % 128) << 25;
        e = CHK && (s < -2048 || s > 2047);
      end
      3: begin
        w = op | ((u / 2048) % 2) << 7 | ((u / 2) % 16) << 8 | f3 << 12 | rs1 << 15 |
            rs2 << 20 | ((u / 32) % 64) << 25 | ((u / 4096) % 2) << 31;
        e = CHK && (s < -4096 || s > 4094 || (u % 2) != 0);
      end
      4: begin
        w = op | rd << 7 | (u / 4096) << 12;
        e = CHK && ((u % 4096) != 0);
      end
      5: begin
        w = op | rd << 7 | ((u / 4096) % 256) << 12 | ((u / 2048) % 2) << 20 |
            ((u / 2) % 1024) << 21 | ((u / 1048576) % 2) << 31;
        e = CHK && (s < -1048576 || s > 1048574 || (u % 2) != 0);
      end
      default: e = 1'b1;
    endcase
    if (e) w = 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input int unsigned fmt, op, f3, f7, rd, rs1, rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = 3'(fmt);
    in_opcode = 7'(op);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
    model_pack(fmt, op, f3, f7, rd, rs1, rs2, imm, pend_instr, pend_err);
  endtask

  // Compare against the scoreboard, clock once, then advance the model.
  task automatic step();
    bit   acc, pop;
    ent_t e;
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("head_instr", out_instr, q[0].instr);
      chk("head_addr", out_addr, q[0].addr);
      chk("head_err", {31'd0, out_err}, {31'd0, q[0].err});
    end
    chk("err_count", {24'd0, err_count}, m_errs);
    acc = in_valid && (q.size() < 2) && !flush;
    pop = out_ready && (q.size() > 0);
    @(posedge clk);
    if (reset) begin
      q.delete(); m_addr = BASE; m_errs = 0;
    end else if (flush) begin
      q.delete(); m_addr = BASE;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.instr = pend_instr; e.addr = m_addr; e.err = pend_err;
        q.push_back(e);
        m_addr = m_addr + 32'd4;
        if (pend_err && m_errs < 255) m_errs++;
      end
    end
    #1;
  endtask

  task automatic directed(input string tag, input int unsigned fmt, op, f3, f7, rd, rs1, rs2,
                          input logic [31:0] imm, input logic [31:0] exp_instr,
                          input logic exp_err, input logic [31:0] exp_addr);
    out_ready = 1'b0;
    req(fmt, op, f3, f7, rd, rs1, rs2, imm);
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    chk({tag, "_addr"}, out_addr, exp_addr);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    req(0, 0, 0, 0, 0, 0, 0, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); m_addr = BASE; m_errs = 0;
    reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    directed("addi", 1, 'h13, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, BASE);
    directed("sw",   2, 'h23, 2, 0, 0, 1, 2, 32'd8,        32'h0020_A423, 1'b0, BASE + 32'd4);
    directed("beq",  3, 'h63, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, BASE + 32'd8);
    directed("jal",  5, 'h6F, 0, 0, 1, 0, 0, 32'd2048,     32'h0010_00EF, 1'b0, BASE + 32'd12);
    directed("srai", 1, 'h13, 5, 'h20, 5, 5, 0, 32'd3,     32'h4032_D293, 1'b0, BASE + 32'd16);
    directed("addi_big", 1, 'h13, 0, 0, 0, 0, 0, 32'd2048,
             CHK ? 32'h0000_0013 : 32'h8000_0013, CHK, BASE + 32'd20);
    chk("errcnt_addi_big", {24'd0, err_count}, CHK ? 32'd1 : 32'd0);
    directed("beq_odd", 3, 'h63, 0, 0, 0, 0, 0, 32'd3,
             CHK ? 32'h0000_0013 : 32'h0000_0163, CHK, BASE + 32'd24);
    chk("errcnt_beq_odd", {24'd0, err_count}, CHK ? 32'd2 : 32'd0);
    directed("illegal", 6, 'h13, 0, 0, 1, 1, 1, 32'd0, 32'h0000_0013, 1'b1, BASE + 32'd28);
    chk("errcnt_illegal", {24'd0, err_count}, CHK ? 32'd3 : 32'd1);

    // Saturation: a stream of illegal-format requests flowing through.
    out_ready = 1'b1;
    req(7, 0, 0, 0, 0, 0, 0, 32'd0);
    repeat (270) step();
    in_valid = 1'b0;
    step();
    chk("errcnt_saturate", {24'd0, err_count}, 32'd255);

    // Reset with an entry buffered.
    out_ready = 1'b0;
    req(1, 'h13, 0, 0, 2, 3, 0, 32'd5);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_errcnt", {24'd0, err_count}, 32'd0);

    // Backpressure: third request held while the FIFO is full.
    req(1, 'h13, 0, 0, 1, 0, 0, 32'd1); step();
    req(1, 'h13, 0, 0, 2, 0, 0, 32'd2); step();
    req(1, 'h13, 0, 0, 3, 0, 0, 32'd3);
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step(); step();
    chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head0_addr", out_addr, BASE);
    out_ready = 1'b1;
    step();
    chk("bp_head1_addr", out_addr, BASE + 32'd4);
    step();
    in_valid = 1'b0;
    chk("bp_head2_addr", out_addr, BASE + 32'd8);
    chk("bp_head2_instr", out_instr, 32'h0030_0193);
    step();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush with one entry held and a request on the same edge.
    out_ready = 1'b0;
    req(6, 0, 0, 0, 0, 0, 0, 32'd0); step();
    req(1, 'h13, 0, 0, 1, 1, 0, 32'd7);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_errcnt", {24'd0, err_count}, 32'd1);
    req(1, 'h13, 0, 0, 1, 1, 0, 32'd7); step();
    in_valid = 1'b0;
    chk("flush_addr", out_addr, BASE);
    out_ready = 1'b1; step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] imm;
      int unsigned fmt, op, mode;
      fmt  = $urandom_range(0, 7);
      op   = $urandom_range(0, 1) ? 'h13 : $urandom_range(0, 127);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2:       imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      req(fmt, op, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
